// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: hazard FSM states, decoder opcodes and default widths.
package pipe_pkg;

   localparam int unsigned DEFAULT_CNT_W    = 16;
   localparam int unsigned DEFAULT_MAX_WAIT = 16;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      BUBBLE   = 2'd1,
      MEM_WAIT = 2'd2
   } hazState_e;

   localparam logic [6:0] OPC_LW    = 7'b0000011;
   localparam logic [6:0] OPC_SW    = 7'b0100011;
   localparam logic [6:0] OPC_BEQ   = 7'b1100011;
   localparam logic [6:0] OPC_RTYPE = 7'b0110011;
   localparam logic [6:0] OPC_IMM   = 7'b0010011;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset; clr together with inc loads 1.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         q <= '0;
      end else if (clr) begin
         q <= inc ? W'(1) : '0;
      end else if (inc && (q != {W{1'b1}})) begin
         q <= q + W'(1);
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / branch-flush / memory-wait hazard controller for the 5-stage RV32I pipe.
// Perf counters are built only when HAZARD_PERF_CNT_EN is defined; otherwise they read 0.
module hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int unsigned MAX_WAIT = DEFAULT_MAX_WAIT,
   parameter int unsigned CNT_W    = DEFAULT_CNT_W
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [4:0]       ifid_rs1_i,
   input  logic [4:0]       ifid_rs2_i,
   input  logic             idex_memread_i,
   input  logic [4:0]       idex_rd_i,
   input  logic             branch_taken_i,
   input  logic             mem_stall_i,
   output logic             noop_o,
   output logic             pc_write_o,
   output logic             ifid_write_o,
   output logic             ifid_flush_o,
   output logic             freeze_o,
   output logic             timeout_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

   hazState_e         state;
   hazState_e         stateNext;
   logic              loadUse;
   logic              waitClr;
   logic              waitInc;
   logic              setTimeout;
   logic              stallEv;
   logic              flushEv;
   logic              timeout;
   logic [WAIT_W-1:0] waitCnt;

   assign loadUse = idex_memread_i && (idex_rd_i != 5'd0) &&
                    ((idex_rd_i == ifid_rs1_i) || (idex_rd_i == ifid_rs2_i));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= RUN;
      end else begin
         state <= stateNext;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         timeout <= 1'b0;
      end else if (setTimeout) begin
         timeout <= 1'b1;
      end
   end

   assign timeout_o = timeout;

   // Mealy decode; an unused encoding falls through to the RUN evaluation
   always_comb begin
      stateNext    = state;
      noop_o       = 1'b0;
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      ifid_flush_o = 1'b0;
      freeze_o     = 1'b0;
      stallEv      = 1'b0;
      flushEv      = 1'b0;
      waitClr      = 1'b1;
      waitInc      = 1'b0;
      setTimeout   = 1'b0;

      if (rst_i) begin
         noop_o    = 1'b1;
         stateNext = RUN;
      end else if ((state == MEM_WAIT) && mem_stall_i) begin
         freeze_o   = 1'b1;
         waitClr    = 1'b0;
         waitInc    = (waitCnt < WAIT_W'(MAX_WAIT));
         setTimeout = (waitCnt >= WAIT_W'(MAX_WAIT - 1));
      end else if (mem_stall_i) begin
         freeze_o   = 1'b1;
         stateNext  = MEM_WAIT;
         waitInc    = 1'b1;
         setTimeout = (MAX_WAIT <= 1);
      end else if (loadUse && (state != BUBBLE)) begin
         // Branch operands are stale behind a load-use pair, so no flush here
         noop_o    = 1'b1;
         stallEv   = 1'b1;
         stateNext = BUBBLE;
      end else begin
         pc_write_o   = 1'b1;
         ifid_write_o = 1'b1;
         stateNext    = RUN;
         if (branch_taken_i) begin
            ifid_flush_o = 1'b1;
            flushEv      = 1'b1;
         end
      end
   end

   sat_counter #(.W(WAIT_W)) uWaitCnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr   (waitClr),
      .inc   (waitInc),
      .q     (waitCnt)
   );

`ifdef HAZARD_PERF_CNT_EN
   sat_counter #(.W(CNT_W)) uStallCnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr   (1'b0),
      .inc   (stallEv),
      .q     (stall_cnt_o)
   );

   sat_counter #(.W(CNT_W)) uFlushCnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr   (1'b0),
      .inc   (flushEv),
      .q     (flush_cnt_o)
   );
`else
   logic unusedEv;
   assign unusedEv    = stallEv ^ flushEv;
   assign stall_cnt_o = '0;
   assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: each row drives one cycle and queues its expected outputs.
module tb_hazard_ctrl;

   localparam int unsigned CW = 2;
   localparam int unsigned MW = 16;

   // {noop, pc_write, ifid_write, ifid_flush, freeze, timeout}
   localparam logic [5:0] O_RUN   = 6'b011000;
   localparam logic [5:0] O_BUB   = 6'b100000;
   localparam logic [5:0] O_FLUSH = 6'b011100;
   localparam logic [5:0] O_FRZ   = 6'b000010;
   localparam logic [5:0] O_RST   = 6'b100000;
   localparam logic [5:0] O_TMO   = 6'b000001;
   localparam logic [1:0] B_NONE  = 2'b00;
   localparam logic [1:0] B_STALL = 2'b10;
   localparam logic [1:0] B_FLUSH = 2'b01;

   typedef struct packed {
      logic          rst;
      logic          mr;
      logic [4:0]    rd;
      logic [4:0]    rs1;
      logic [4:0]    rs2;
      logic          br;
      logic          ms;
      logic [5:0]    o;
      logic [1:0]    bump;
   } row_t;

   typedef struct packed {
      logic [5:0]    o;
      logic [CW-1:0] sc;
      logic [CW-1:0] fc;
   } obs_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [4:0]    rs1 = '0;
   logic [4:0]    rs2 = '0;
   logic          memRead = 1'b0;
   logic [4:0]    rd = '0;
   logic          br = 1'b0;
   logic          ms = 1'b1;
   logic          noop;
   logic          pcWrite;
   logic          ifidWrite;
   logic          ifidFlush;
   logic          freeze;
   logic          timeout;
   logic [CW-1:0] stallCnt;
   logic [CW-1:0] flushCnt;

   obs_t expQ[$];
   row_t rows[$];
   int   checks   = 0;
   int   failures = 0;
   int   tallyS   = 0;
   int   tallyF   = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.MAX_WAIT(MW), .CNT_W(CW)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .ifid_rs1_i     (rs1),
      .ifid_rs2_i     (rs2),
      .idex_memread_i (memRead),
      .idex_rd_i      (rd),
      .branch_taken_i (br),
      .mem_stall_i    (ms),
      .noop_o         (noop),
      .pc_write_o     (pcWrite),
      .ifid_write_o   (ifidWrite),
      .ifid_flush_o   (ifidFlush),
      .freeze_o       (freeze),
      .timeout_o      (timeout),
      .stall_cnt_o    (stallCnt),
      .flush_cnt_o    (flushCnt)
   );

   function automatic logic [CW-1:0] expCnt(input int v);
`ifdef HAZARD_PERF_CNT_EN
      if (v >= int'(2 ** CW - 1)) return '1;
      return CW'(v);
`else
      if (v < 0) return '1;
      return '0;
`endif
   endfunction

   function automatic obs_t sample();
      obs_t s;
      s.o  = {noop, pcWrite, ifidWrite, ifidFlush, freeze, timeout};
      s.sc = stallCnt;
      s.fc = flushCnt;
      return s;
   endfunction

   task automatic add(input logic rstV, input logic mrV, input int rdV, input int rs1V,
                      input int rs2V, input logic brV, input logic msV,
                      input logic [5:0] oV, input logic [1:0] bumpV);
      row_t r;
      r.rst  = rstV;
      r.mr   = mrV;
      r.rd   = 5'(rdV);
      r.rs1  = 5'(rs1V);
      r.rs2  = 5'(rs2V);
      r.br   = brV;
      r.ms   = msV;
      r.o    = oV;
      r.bump = bumpV;
      rows.push_back(r);
   endtask

   // Drive one cycle and queue its expectation; counters show events of earlier cycles
   task automatic drive(input row_t r);
      obs_t e;
      @(posedge clk);
      #1;
      rst     = r.rst;
      memRead = r.mr;
      rd      = r.rd;
      rs1     = r.rs1;
      rs2     = r.rs2;
      br      = r.br;
      ms      = r.ms;
      e.o  = r.o;
      e.sc = expCnt(tallyS);
      e.fc = expCnt(tallyF);
      expQ.push_back(e);
      if (r.rst) begin
         tallyS = 0;
         tallyF = 0;
      end else begin
         tallyS += int'(r.bump[1]);
         tallyF += int'(r.bump[0]);
      end
   endtask

   task automatic test_reset();
      obs_t got, exp;
      rows.delete();
      add(1, 0, 0, 0, 0, 0, 1, O_RST, B_NONE);
      add(1, 1, 5, 5, 5, 1, 1, O_RST, B_NONE);
      add(0, 0, 0, 0, 0, 0, 0, O_RUN, B_NONE);
      for (int i = 0; i < rows.size(); i++) begin
         drive(rows[i]);
         @(negedge clk);
         got = sample();
         exp = expQ.pop_front();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL reset row%0d got=%b expected=%b", i, got, exp);
         end
      end
   endtask

   task automatic test_load_use();
      obs_t got, exp;
      rows.delete();
      add(0, 1, 5, 0, 5, 0, 0, O_BUB, B_STALL);
      add(0, 1, 5, 0, 5, 0, 0, O_RUN, B_NONE);
      add(0, 0, 0, 0, 0, 0, 0, O_RUN, B_NONE);
      add(0, 1, 0, 0, 0, 0, 0, O_RUN, B_NONE);
      add(0, 1, 0, 0, 0, 0, 0, O_RUN, B_NONE);
      add(0, 0, 5, 0, 5, 0, 0, O_RUN, B_NONE);
      add(0, 1, 7, 7, 1, 0, 0, O_BUB, B_STALL);
      add(0, 1, 7, 7, 1, 0, 0, O_RUN, B_NONE);
      add(0, 0, 0, 0, 0, 0, 0, O_RUN, B_NONE);
      for (int i = 0; i < rows.size(); i++) begin
         drive(rows[i]);
         @(negedge clk);
         got = sample();
         exp = expQ.pop_front();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL load_use row%0d got=%b expected=%b", i, got, exp);
         end
      end
   endtask

   task automatic test_branch();
      obs_t got, exp;
      rows.delete();
      add(0, 0, 0, 0, 0, 1, 0, O_FLUSH, B_FLUSH);
      add(0, 0, 0, 0, 0, 0, 0, O_RUN,   B_NONE);
      add(0, 1, 3, 3, 0, 1, 0, O_BUB,   B_STALL);
      add(0, 1, 3, 3, 0, 1, 0, O_FLUSH, B_FLUSH);
      add(0, 0, 0, 0, 0, 0, 0, O_RUN,   B_NONE);
      for (int i = 0; i < rows.size(); i++) begin
         drive(rows[i]);
         @(negedge clk);
         got = sample();
         exp = expQ.pop_front();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL branch row%0d got=%b expected=%b", i, got, exp);
         end
      end
   endtask

   task automatic test_mem_wait();
      obs_t got, exp;
      rows.delete();
      for (int k = 0; k < 5; k++) add(0, 1, 4, 0, 4, 1, 1, O_FRZ, B_NONE);
      add(0, 1, 4, 0, 4, 1, 0, O_BUB,   B_STALL);
      add(0, 1, 4, 0, 4, 1, 0, O_FLUSH, B_FLUSH);
      add(0, 0, 0, 0, 0, 0, 0, O_RUN,   B_NONE);
      add(0, 1, 9, 9, 0, 0, 0, O_BUB,   B_STALL);
      add(0, 1, 9, 9, 0, 0, 1, O_FRZ,   B_NONE);
      add(0, 0, 0, 0, 0, 0, 0, O_RUN,   B_NONE);
      add(0, 0, 0, 0, 0, 0, 0, O_RUN,   B_NONE);
      for (int i = 0; i < rows.size(); i++) begin
         drive(rows[i]);
         @(negedge clk);
         got = sample();
         exp = expQ.pop_front();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL mem_wait row%0d got=%b expected=%b", i, got, exp);
         end
      end
   endtask

   task automatic test_watchdog();
      obs_t got, exp;
      rows.delete();
      for (int k = 1; k <= 20; k++) add(0, 0, 0, 0, 0, 0, 1, (k >= 17) ? (O_FRZ | O_TMO) : O_FRZ, B_NONE);
      add(0, 0, 0, 0, 0, 0, 0, O_RUN | O_TMO, B_NONE);
      add(0, 0, 0, 0, 0, 1, 0, O_FLUSH | O_TMO, B_FLUSH);
      add(1, 0, 0, 0, 0, 0, 0, O_RST | O_TMO, B_NONE);
      add(0, 0, 0, 0, 0, 0, 0, O_RUN, B_NONE);
      for (int i = 0; i < rows.size(); i++) begin
         drive(rows[i]);
         @(negedge clk);
         got = sample();
         exp = expQ.pop_front();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL watchdog row%0d got=%b expected=%b", i, got, exp);
         end
      end
   endtask

   task automatic test_saturation();
      obs_t got, exp;
      rows.delete();
      for (int k = 0; k < 5; k++) add(0, 0, 0, 0, 0, 1, 0, O_FLUSH, B_FLUSH);
      add(0, 0, 0, 0, 0, 0, 0, O_RUN, B_NONE);
      for (int i = 0; i < rows.size(); i++) begin
         drive(rows[i]);
         @(negedge clk);
         got = sample();
         exp = expQ.pop_front();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL saturation row%0d got=%b expected=%b", i, got, exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      obs_t got, exp;
      rows.delete();
      for (int k = 0; k < 4; k++) begin
         add(0, 1, 12, 12, 12, 0, 0, O_BUB, B_STALL);
         add(0, 1, 12, 12, 12, 0, 0, O_RUN, B_NONE);
      end
      add(0, 0, 0, 0, 0, 0, 0, O_RUN, B_NONE);
      for (int i = 0; i < rows.size(); i++) begin
         drive(rows[i]);
         @(negedge clk);
         got = sample();
         exp = expQ.pop_front();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL back_to_back row%0d got=%b expected=%b", i, got, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch();
      test_mem_wait();
      test_watchdog();
      test_saturation();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard/stall controller for the 5-stage RV32I pipeline. Sits directly upstream of the ID-stage control decoder.
- Generates the decoder's NoOp bubble request, PC/IF-ID write enables, the IF/ID flush, and a whole-pipe freeze for multi-cycle data-memory waits.
- Holds a small FSM, a wait watchdog and saturating event counters.

Parameters:
- MAX_WAIT, 16: max consecutive MEM_WAIT cycles before timeout_o is raised.
- CNT_W, 16: width of the performance counters.

Ports:
- clk_i  in  1  pipeline clock.
- rst_i  in  1  synchronous, active-high reset.
- ifid_rs1_i  in  5  rs1 field of the instruction in IF/ID.
- ifid_rs2_i  in  5  rs2 field of the instruction in IF/ID.
- idex_memread_i  in  1  MemRead of the instruction in ID/EX.
- idex_rd_i  in  5  rd of the instruction in ID/EX.
- branch_taken_i  in  1  beq resolved taken in ID this cycle.
- mem_stall_i  in  1  data memory busy; the MEM stage cannot complete.
- noop_o  out  1  to the decoder NoOp input; forces all control outputs to 0.
- pc_write_o  out  1  PC update enable.
- ifid_write_o  out  1  IF/ID register write enable.
- ifid_flush_o  out  1  clears IF/ID to a bubble (instruction 0).
- freeze_o  out  1  holds ID/EX, EX/MEM and MEM/WB.
- timeout_o  out  1  sticky watchdog flag.
- stall_cnt_o  out  CNT_W  load-use bubbles inserted.
- flush_cnt_o  out  CNT_W  taken-branch flushes.

Behaviour:
- Reset is synchronous and active-high. Clock port is clk_i, reset port is rst_i.
- While rst_i is high, and in the cycle it is sampled:
  - noop_o=1, pc_write_o=0, ifid_write_o=0, ifid_flush_o=0, freeze_o=0.
  - Next state is RUN; timeout_o, stall_cnt_o, flush_cnt_o and the wait counter clear to 0.
  - Reset mid-MEM_WAIT abandons the wait.
- State is registered. Outputs are combinational from state and current inputs (Mealy).
- Load-use condition lu = idex_memread_i && idex_rd_i!=0 && (idex_rd_i==ifid_rs1_i || idex_rd_i==ifid_rs2_i).
- RUN, evaluated in priority order:
  - (1) mem_stall_i=1: freeze_o=1, pc_write_o=0, ifid_write_o=0, noop_o=0, no flush; next state MEM_WAIT, wait counter loads 1.
  - (2) lu=1: noop_o=1, pc_write_o=0, ifid_write_o=0, ifid_flush_o=0 even if branch_taken_i=1, because the branch operands are stale. stall_cnt increments. Next state BUBBLE.
  - (3) branch_taken_i=1: ifid_flush_o=1, pc_write_o=1, ifid_write_o=1. flush_cnt increments. Stay RUN.
  - (4) otherwise: pc_write_o=1, ifid_write_o=1, all other outputs 0.
- BUBBLE: lasts exactly one cycle, then the load has moved to EX/MEM.
  - Outputs as in RUN, but lu is ignored, so a second bubble is never inserted for the same pair.
  - mem_stall_i still has priority.
  - Next state is RUN, or MEM_WAIT if mem_stall_i=1.
- MEM_WAIT:
  - freeze_o=1, pc_write_o=0, ifid_write_o=0, noop_o=0, ifid_flush_o=0.
  - branch_taken_i and lu are ignored; the ID instruction is re-evaluated after the wait.
  - Wait counter increments (saturates at MAX_WAIT). When it reaches MAX_WAIT while mem_stall_i=1, timeout_o sets and stays set until reset.
  - mem_stall_i=0 gives RUN outputs in that same cycle, and next state is RUN.
- Counters saturate at 2^CNT_W-1 (no wrap).
- State encoding (2 bits): RUN=0, BUBBLE=1, MEM_WAIT=2. Encoding 3 returns to RUN with RUN outputs.

Optional Feature:
- HAZARD_PERF_CNT_EN defined: stall_cnt_o and flush_cnt_o are implemented as above.
- Not defined: no counter flops; both outputs are tied to 0. Ports remain, so the interface is unchanged.
- Watchdog and timeout_o are present in both builds.

Decomposition:
- Shared package/header pipe_pkg:
  - FSM state constants (RUN, BUBBLE, MEM_WAIT).
  - Opcode constants (lw, sw, beq, rtype, imm), shared with the decoder.
  - Default CNT_W.
- One sub-module: sat_counter (parameter W; inputs clk_i, rst_i, clr, inc; output q, saturating). Instantiated for the wait counter and both perf counters.

Test Plan:
- Reset: hold rst_i 2 cycles with mem_stall_i=1 -> noop_o=1, pc_write_o=0, freeze_o=0, counters 0; first cycle after reset with quiet inputs gives pc_write_o=1.
- Load-use: idex_memread_i=1, idex_rd_i=5, ifid_rs2_i=5 held 2 cycles -> exactly one cycle noop_o=1, pc_write_o=0; next cycle pc_write_o=1; stall_cnt_o=1. Repeat with idex_rd_i=0 -> no bubble.
- Branch flush vs load-use: branch_taken_i=1 alone -> ifid_flush_o=1, flush_cnt_o=1. Same cycle as lu=1 -> ifid_flush_o=0, noop_o=1, flush_cnt_o unchanged.
- Memory wait: mem_stall_i=1 for 5 cycles with lu=1 and branch_taken_i=1 -> freeze_o=1 for 5 cycles, noop_o=0, no flush. Release -> RUN; lu re-evaluated and gives one bubble.
- Watchdog: mem_stall_i=1 for 20 cycles with MAX_WAIT=16 -> timeout_o rises on the cycle the wait count reaches 16 and stays 1 after release, until rst_i.
- Saturation: CNT_W=2, 5 branch flushes -> flush_cnt_o=3. Without HAZARD_PERF_CNT_EN -> both counter outputs remain 0.
